// File: rtl/mem_checker_pkg.sv
// Shared types for the memory checker.
//   ADDR_W / DATA_W : Avalon address and data widths
//   cmp_struct_t    : compare FIFO entry, packed {addr, data}
//   rd_cmp_state_t  : read/compare sequencer states
package mem_checker_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmp_struct_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } rd_cmp_state_t;

endpackage

// File: rtl/rd_cmp_wdog.sv
// Read-return watchdog for rd_cmp_ctrl.
// Down-counter reloaded by kick_i; timeout_o becomes sticky when the count
// expires and is only cleared by clear_i (or reset).
//   clk_i, rst_n_i : clock, async active-low reset
//   kick_i         : reload the counter (return seen, or nothing in flight)
//   clear_i        : clear the sticky flag
//   timeout_o      : sticky watchdog flag
module rd_cmp_wdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic kick_i,
    input  logic clear_i,
    output logic timeout_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q     <= LOAD;
            timeout_o <= 1'b0;
        end else begin
            if (kick_i) begin
                cnt_q <= LOAD;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            // Last decrement is the TIMEOUT_CYCLES-th unkicked cycle.
            if (clear_i) begin
                timeout_o <= 1'b0;
            end else if (!kick_i && cnt_q == CNT_W'(1)) begin
                timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rd_cmp_ctrl.sv
// Read-and-compare sequencer for the memory checker.
// Issues read commands on an Avalon-MM read port, pushes {addr, expected data}
// into an external compare FIFO (2**AWIDTH deep, registered q), pops it when
// read data returns and reports mismatches. Owns the FIFO credit count.
// Optional watchdog: define RD_CMP_TIMEOUT_EN to build rd_cmp_wdog; otherwise
// timeout_o is tied low.
//   cmd_*        : command in (valid/ready, address, expected data)
//   mem_*        : Avalon-MM read master
//   fifo_*       : compare FIFO control/data (FIFO lives beside this block)
//   clear_i      : clears err_cnt_o, orphan_o, timeout_o
//   outstanding_o: entries in flight
//   err_*        : mismatch pulse, address and saturating count
//   orphan_o     : sticky, data returned with nothing outstanding
//   timeout_o    : sticky watchdog flag
//
// state | meaning
// IDLE  | ready for a command when credit is available
// REQ   | read request on Avalon, held until waitrequest drops
module rd_cmp_ctrl
    import mem_checker_pkg::*;
#(
    parameter int AWIDTH         = 4,
    parameter int ERR_CNT_W      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [ADDR_W-1:0]    cmd_addr_i,
    input  logic [DATA_W-1:0]    cmd_data_i,
    output logic                 mem_read_o,
    output logic [ADDR_W-1:0]    mem_address_o,
    input  logic                 mem_waitrequest_i,
    input  logic                 mem_readdatavalid_i,
    input  logic [DATA_W-1:0]    mem_readdata_i,
    output logic                 fifo_srst_o,
    output logic                 fifo_wrreq_o,
    output cmp_struct_t          fifo_data_o,
    output logic                 fifo_rdreq_o,
    input  cmp_struct_t          fifo_q_i,
    input  logic                 clear_i,
    output logic [AWIDTH:0]      outstanding_o,
    output logic                 err_valid_o,
    output logic [ADDR_W-1:0]    err_addr_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic                 orphan_o,
    output logic                 timeout_o
);

    localparam logic [AWIDTH:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};

    rd_cmp_state_t     state_q, state_d;
    logic [1:0]        srst_sync;
    logic              can_accept;
    logic              accept;
    logic              pop;
    logic              cmp_pending;
    logic [DATA_W-1:0] rd_data_q;
    logic              mismatch;

    // FIFO reset is released two edges after rst_n_i so the FIFO sees at
    // least one full clock of synchronous reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            srst_sync <= 2'b00;
        end else begin
            srst_sync <= {srst_sync[0], 1'b1};
        end
    end
    assign fifo_srst_o = ~srst_sync[1];

    assign can_accept = (outstanding_o < DEPTH) && !fifo_srst_o && !timeout_o;

    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        mem_read_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready_o = can_accept;
                if (cmd_valid_i && can_accept) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_read_o = 1'b1;
                if (!mem_waitrequest_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept       = cmd_valid_i && cmd_ready_o;
    assign pop          = mem_readdatavalid_i && (outstanding_o != '0);
    assign fifo_wrreq_o = accept;
    assign fifo_data_o  = '{addr: cmd_addr_i, data: cmd_data_i};
    assign fifo_rdreq_o = pop;

    // FIFO q is valid the cycle after the pop, alongside the registered data.
    assign mismatch = cmp_pending && (fifo_q_i.data != rd_data_q);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            mem_address_o <= '0;
            outstanding_o <= '0;
            rd_data_q     <= '0;
            cmp_pending   <= 1'b0;
            err_valid_o   <= 1'b0;
            err_addr_o    <= '0;
            err_cnt_o     <= '0;
            orphan_o      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mem_address_o <= cmd_addr_i;
            end
            unique case ({accept, pop})
                2'b10:   outstanding_o <= outstanding_o + 1'b1;
                2'b01:   outstanding_o <= outstanding_o - 1'b1;
                default: ;
            endcase
            cmp_pending <= pop;
            if (pop) begin
                rd_data_q <= mem_readdata_i;
            end
            err_valid_o <= mismatch;
            if (mismatch) begin
                err_addr_o <= fifo_q_i.addr;
            end
            if (clear_i) begin
                err_cnt_o <= '0;
            end else if (mismatch && (err_cnt_o != '1)) begin
                err_cnt_o <= err_cnt_o + 1'b1;
            end
            if (clear_i) begin
                orphan_o <= 1'b0;
            end else if (mem_readdatavalid_i && (outstanding_o == '0)) begin
                orphan_o <= 1'b1;
            end
        end
    end

`ifdef RD_CMP_TIMEOUT_EN
    rd_cmp_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .kick_i   (mem_readdatavalid_i || (outstanding_o == '0)),
        .clear_i  (clear_i),
        .timeout_o(timeout_o)
    );
`else
    assign timeout_o = 1'b0;
`endif

endmodule
